// File: rtl/ram_write_sequencer_pkg.sv
// Shared definitions for the byte-matrix RAM write sequencer.
//   Address map of the 29-entry RAM: A 4x4 at 0-15, B 3x3 at 16-24,
//   C 2x2 at 25-28. Also holds the bus widths and the FSM state encoding.
package ram_write_sequencer_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;

    localparam int A_BASE    = 0;
    localparam int B_BASE    = 16;
    localparam int C_BASE    = 25;
    localparam int MEM_DEPTH = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_write_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
//   master : load requester / stream source / result source / RAM sink
//            (drives requests, stream bytes and results; observes writes)
//   slave  : the sequencer itself
// Signals:
//   load_start, load_base, load_len        load request
//   s_data, s_valid / s_ready              byte stream handshake
//   res_valid, res_c00..res_c11 / res_ready 2x2 result handshake
//   ram_addr, ram_in, ram_en               RAM write port
//   busy, done, err                        status
interface ram_write_sequencer_if;
    import ram_write_sequencer_pkg::*;

    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W-1:0] load_len;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic              res_valid;
    logic [DATA_W-1:0] res_c00;
    logic [DATA_W-1:0] res_c01;
    logic [DATA_W-1:0] res_c10;
    logic [DATA_W-1:0] res_c11;
    logic              res_ready;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_in;
    logic              ram_en;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_start, load_base, load_len,
        output s_data, s_valid,
        input  s_ready,
        output res_valid, res_c00, res_c01, res_c10, res_c11,
        input  res_ready,
        input  ram_addr, ram_in, ram_en,
        input  busy, done, err
    );

    modport slave (
        input  load_start, load_base, load_len,
        input  s_data, s_valid,
        output s_ready,
        input  res_valid, res_c00, res_c01, res_c10, res_c11,
        output res_ready,
        output ram_addr, ram_in, ram_en,
        output busy, done, err
    );

endinterface

// File: rtl/ram_write_sequencer.sv
// Write-side initiator for the 29-entry byte matrix RAM.
//   - LOAD   : streams load_len bytes into consecutive addresses from
//              load_base; stream bytes pass straight through to the RAM port.
//   - COMMIT : writes a captured 2x2 result to c00..c11 at C_BASE..C_BASE+3.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  ram_write_sequencer_if.slave (requests, stream, result, RAM port,
//        busy/done/err status)
module ram_write_sequencer #(
    parameter int ADDR_W    = ram_write_sequencer_pkg::ADDR_W,
    parameter int DATA_W    = ram_write_sequencer_pkg::DATA_W,
    parameter int MEM_DEPTH = ram_write_sequencer_pkg::MEM_DEPTH,
    parameter int C_BASE    = ram_write_sequencer_pkg::C_BASE
) (
    input  logic                          clk,
    input  logic                          rst,
    ram_write_sequencer_if.slave          bus
);
    import ram_write_sequencer_pkg::*;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0][DATA_W-1:0]  cap_q, cap_d;
    logic                    err_q, err_d;

    logic                    s_ready_c;
    logic                    res_ready_c;
    logic                    ram_en_c;
    logic [ADDR_W-1:0]       ram_addr_c;
    logic [DATA_W-1:0]       ram_in_c;

    // One extra bit so base+len cannot wrap before the depth compare.
    logic [ADDR_W:0]         load_end;
    logic                    load_reject;

    assign load_end    = {1'b0, bus.load_base} + {1'b0, bus.load_len};
    assign load_reject = (bus.load_len == '0) ||
                         (load_end > (ADDR_W+1)'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        err_d       = 1'b0;
        s_ready_c   = 1'b0;
        res_ready_c = 1'b0;
        ram_en_c    = 1'b0;
        ram_addr_c  = '0;
        ram_in_c    = '0;

        unique case (state_q)
            IDLE: begin
                // A load request takes priority over a pending result.
                if (bus.load_start) begin
                    if (load_reject) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = bus.load_base;
                        cnt_d   = bus.load_len;
                        state_d = LOAD;
                    end
                end else if (bus.res_valid) begin
                    res_ready_c = 1'b1;
                    cap_d       = {bus.res_c11, bus.res_c10, bus.res_c01, bus.res_c00};
                    idx_d       = '0;
                    state_d     = COMMIT;
                end
            end
            LOAD: begin
                s_ready_c  = 1'b1;
                ram_en_c   = bus.s_valid;
                ram_addr_c = ptr_q;
                ram_in_c   = bus.s_data;
                if (bus.s_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            COMMIT: begin
                ram_en_c   = 1'b1;
                ram_addr_c = ADDR_W'(C_BASE) + ADDR_W'(idx_q);
                ram_in_c   = cap_q[idx_q];
                idx_d      = idx_q + 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted nothing may reach the RAM or the handshakes.
        if (!rst) begin
            s_ready_c   = 1'b0;
            res_ready_c = 1'b0;
            ram_en_c    = 1'b0;
            ram_addr_c  = '0;
            ram_in_c    = '0;
        end
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.res_ready = res_ready_c;
    assign bus.ram_en    = ram_en_c;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_in    = ram_in_c;
    assign bus.busy      = rst && (state_q != IDLE);
    assign bus.done      = rst && (state_q == DONE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Self-checking bench for ram_write_sequencer.
module tb_ram_write_sequencer;
    import ram_write_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_write_sequencer_if bus();

    ram_write_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [4:0] base;
        logic [4:0] len;
        bit         rej;
    } load_vec_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_wr  = 0;
    wr_t exp_q[$];
    logic [7:0] shadow  [MEM_DEPTH];
    logic [7:0] mem_obs [MEM_DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int a, input logic [7:0] d);
        wr_t w;
        w.a = 5'(a);
        w.d = d;
        exp_q.push_back(w);
        shadow[a] = d;
    endtask

    // RAM model and write scoreboard: each observed write must match the
    // oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.ram_en === 1'b1) begin
            n_wr++;
            check("wr_range", 32'(bus.ram_addr < 5'(MEM_DEPTH)), 1);
            if (bus.ram_addr < 5'(MEM_DEPTH)) mem_obs[bus.ram_addr] = bus.ram_in;
            if (exp_q.size() == 0) begin
                fail_now($sformatf("unexpected_write addr=%0d data=%0d", bus.ram_addr, bus.ram_in));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.ram_addr), 32'(e.a));
                check("wr_data", 32'(bus.ram_in), 32'(e.d));
            end
        end
    end

    // Feeds len stream bytes (starting in the first LOAD cycle) with random
    // valid gaps, then checks the done cycle.
    task automatic run_load(input int base, input int len, input int gap_pct, input bit noise);
        int sent  = 0;
        int guard = 0;
        bit first = 1;
        while (sent < len && guard < 500) begin
            bus.s_valid = ($urandom_range(99) >= gap_pct);
            bus.s_data  = 8'($urandom);
            if (noise) bus.res_valid = 1'($urandom);
            if (bus.s_valid) expect_write(base + sent, bus.s_data);
            @(negedge clk);
            if (first) begin
                check("load_err_low", 32'(bus.err), 0);
                check("load_busy", 32'(bus.busy), 1);
                first = 0;
            end
            check("load_s_ready", 32'(bus.s_ready), 1);
            check("load_res_ready", 32'(bus.res_ready), 0);
            check("load_ram_en", 32'(bus.ram_en), 32'(bus.s_valid));
            if (bus.s_valid) sent++;
            tick();
            guard++;
        end
        if (guard >= 500) fail_now("load_timeout");
        bus.s_valid = 1'b0;
        if (noise) bus.res_valid = 1'b0;
        @(negedge clk);
        check("load_done", 32'(bus.done), 1);
        check("load_done_s_ready", 32'(bus.s_ready), 0);
        tick();
    endtask

    task automatic do_load(input int base, input int len, input bit rej, input bit noise);
        int wr0;
        wr0 = n_wr;
        bus.load_start = 1'b1;
        bus.load_base  = 5'(base);
        bus.load_len   = 5'(len);
        @(negedge clk);
        check("req_err_pre", 32'(bus.err), 0);
        tick();
        bus.load_start = 1'b0;
        if (rej) begin
            @(negedge clk);
            check("rej_err", 32'(bus.err), 1);
            check("rej_busy", 32'(bus.busy), 0);
            check("rej_ram_en", 32'(bus.ram_en), 0);
            tick();
            @(negedge clk);
            check("rej_err_pulse", 32'(bus.err), 0);
            check("rej_busy2", 32'(bus.busy), 0);
            tick();
            check("rej_no_writes", 32'(n_wr - wr0), 0);
        end else begin
            run_load(base, len, 30, noise);
            check("load_write_count", 32'(n_wr - wr0), 32'(len));
        end
    endtask

    // Handshake in the current cycle, writes on the next four, done on the fifth.
    task automatic do_commit(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        bus.res_valid = 1'b1;
        bus.res_c00 = c0; bus.res_c01 = c1; bus.res_c10 = c2; bus.res_c11 = c3;
        @(negedge clk);
        check("cm_res_ready", 32'(bus.res_ready), 1);
        for (int i = 0; i < 4; i++) expect_write(C_BASE + i, c[i]);
        tick();
        bus.res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cm_ram_en", 32'(bus.ram_en), 1);
            check("cm_addr", 32'(bus.ram_addr), 32'(C_BASE + i));
            check("cm_data", 32'(bus.ram_in), 32'(c[i]));
            check("cm_res_ready_low", 32'(bus.res_ready), 0);
            tick();
        end
        @(negedge clk);
        check("cm_done", 32'(bus.done), 1);
        check("cm_done_no_write", 32'(bus.ram_en), 0);
        check("cm_done_busy", 32'(bus.busy), 1);
        tick();
        @(negedge clk);
        check("cm_idle_busy", 32'(bus.busy), 0);
        check("cm_idle_done", 32'(bus.done), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    load_vec_t vecs [9];
    logic [7:0] bbytes [9];

    initial begin
        bus.load_start = 0; bus.load_base = 0; bus.load_len = 0;
        bus.s_data = 0; bus.s_valid = 0;
        bus.res_valid = 0;
        bus.res_c00 = 0; bus.res_c01 = 0; bus.res_c10 = 0; bus.res_c11 = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            shadow[i]  = 8'h00;
            mem_obs[i] = 8'h00;
        end

        vecs[0] = '{5'd25, 5'd5,  1'b1};
        vecs[1] = '{5'd3,  5'd0,  1'b1};
        vecs[2] = '{5'd25, 5'd4,  1'b0};
        vecs[3] = '{5'd28, 5'd1,  1'b0};
        vecs[4] = '{5'd28, 5'd2,  1'b1};
        vecs[5] = '{5'd0,  5'd29, 1'b0};
        vecs[6] = '{5'd0,  5'd30, 1'b1};
        vecs[7] = '{5'd31, 5'd1,  1'b1};
        vecs[8] = '{5'd20, 5'd31, 1'b1};

        bbytes = '{8'd2, 8'd3, 8'd2, 8'd4, 8'd6, 8'd5, 8'd1, 8'd7, 8'd1};

        // Reset held with a pending result: everything stays quiet.
        rst = 1'b0;
        bus.res_valid = 1'b1;
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst_ram_en", 32'(bus.ram_en), 0);
            check("rst_res_ready", 32'(bus.res_ready), 0);
            check("rst_s_ready", 32'(bus.s_ready), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_done", 32'(bus.done), 0);
            check("rst_err", 32'(bus.err), 0);
            check("rst_addr", 32'(bus.ram_addr), 0);
        end
        tick();
        rst = 1'b1;

        // Release: result accepted in the same cycle, then written to C.
        do_commit(8'd10, 8'd20, 8'd30, 8'd40);

        // Load B with a two-cycle gap after the third byte.
        begin
            int wr0;
            int i;
            wr0 = n_wr;
            bus.load_start = 1'b1; bus.load_base = 5'd16; bus.load_len = 5'd9;
            @(negedge clk);
            check("lb_idle_s_ready", 32'(bus.s_ready), 0);
            tick();
            bus.load_start = 1'b0;
            i = 0;
            while (i < 9) begin
                if (i == 3) begin
                    for (int g = 0; g < 2; g++) begin
                        bus.s_valid = 1'b0;
                        bus.s_data  = 8'hEE;
                        @(negedge clk);
                        check("lb_gap_ram_en", 32'(bus.ram_en), 0);
                        check("lb_gap_s_ready", 32'(bus.s_ready), 1);
                        tick();
                    end
                end
                bus.s_valid = 1'b1;
                bus.s_data  = bbytes[i];
                expect_write(16 + i, bbytes[i]);
                @(negedge clk);
                check("lb_ram_en", 32'(bus.ram_en), 1);
                check("lb_addr", 32'(bus.ram_addr), 32'(16 + i));
                check("lb_data", 32'(bus.ram_in), 32'(bbytes[i]));
                tick();
                i++;
            end
            bus.s_valid = 1'b0;
            @(negedge clk);
            check("lb_done", 32'(bus.done), 1);
            check("lb_done_s_ready", 32'(bus.s_ready), 0);
            tick();
            @(negedge clk);
            check("lb_idle_busy", 32'(bus.busy), 0);
            tick();
            check("lb_write_count", 32'(n_wr - wr0), 9);
        end

        // Table of load requests around the range check.
        for (int v = 0; v < 9; v++) begin
            do_load(int'(vecs[v].base), int'(vecs[v].len), vecs[v].rej, 1'b0);
        end

        // Load and result in the same cycle: load wins, result taken after done.
        bus.res_valid = 1'b1;
        bus.res_c00 = 8'd91; bus.res_c01 = 8'd92; bus.res_c10 = 8'd93; bus.res_c11 = 8'd94;
        bus.load_start = 1'b1; bus.load_base = 5'd0; bus.load_len = 5'd16;
        @(negedge clk);
        check("cf_res_ready", 32'(bus.res_ready), 0);
        tick();
        bus.load_start = 1'b0;
        run_load(0, 16, 0, 1'b0);
        do_commit(8'd91, 8'd92, 8'd93, 8'd94);

        // Reset after two commit writes: the rest of the commit is abandoned.
        begin
            int wr0;
            wr0 = n_wr;
            bus.res_valid = 1'b1;
            bus.res_c00 = 8'd1; bus.res_c01 = 8'd2; bus.res_c10 = 8'd3; bus.res_c11 = 8'd4;
            @(negedge clk);
            check("mr_res_ready", 32'(bus.res_ready), 1);
            expect_write(C_BASE + 0, 8'd1);
            expect_write(C_BASE + 1, 8'd2);
            tick();
            bus.res_valid = 1'b0;
            tick();
            tick();
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("mr_ram_en", 32'(bus.ram_en), 0);
                check("mr_done", 32'(bus.done), 0);
                tick();
            end
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("mr_idle_busy", 32'(bus.busy), 0);
                check("mr_idle_done", 32'(bus.done), 0);
                check("mr_idle_ram_en", 32'(bus.ram_en), 0);
                tick();
            end
            check("mr_write_count", 32'(n_wr - wr0), 2);
        end

        // Randomised mix of legal loads, illegal loads and commits.
        for (int k = 0; k < 40; k++) begin
            int op;
            int base;
            int len;
            op = int'($urandom_range(2));
            if (op == 0) begin
                base = int'($urandom_range(MEM_DEPTH - 1));
                len  = int'($urandom_range(MEM_DEPTH - base, 1));
                do_load(base, len, 1'b0, 1'b1);
            end else if (op == 1) begin
                base = int'($urandom_range(31));
                if ($urandom_range(1) == 0) len = 0;
                else if (base >= MEM_DEPTH) len = int'($urandom_range(31, 1));
                else len = int'($urandom_range(31, MEM_DEPTH + 1 - base));
                do_load(base, len, 1'b1, 1'b0);
            end else begin
                do_commit(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        tick();
        check("pending_writes", 32'(exp_q.size()), 0);
        for (int a = 0; a < MEM_DEPTH; a++) begin
            check($sformatf("ram[%0d]", a), 32'(mem_obs[a]), 32'(shadow[a]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_write_sequencer.md
Name: ram_write_sequencer

Overview:
- Write-side initiator for the 29-entry byte matrix RAM (A 4x4 at 0-15, B 3x3 at 16-24, C 2x2 at 25-28).
- Drives the RAM write port (addr/in/en). Two jobs:
  - Bulk-load operands from a byte stream.
  - Commit a 2x2 convolution result captured in one handshake.
- Sits between the host/stream source, the systolic array result path, and the RAM.

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 8, data byte width
- MEM_DEPTH, 29, number of RAM entries; legal addresses 0..MEM_DEPTH-1
- C_BASE, 25, address of c00; c01, c10 and c11 follow at +1, +2, +3

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- load_start  in  1  one-cycle request to begin a stream load
- load_base  in  ADDR_W  first address of the load
- load_len  in  ADDR_W  number of bytes to load, 1..MEM_DEPTH
- s_data  in  DATA_W  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  sequencer accepts a stream byte
- res_valid  in  1  2x2 result available
- res_c00, res_c01, res_c10, res_c11  in  DATA_W each  result bytes
- res_ready  out  1  result accepted when res_valid and res_ready are both high
- ram_addr  out  ADDR_W  RAM write address
- ram_in  out  DATA_W  RAM write data
- ram_en  out  1  RAM write enable
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a load or commit finishes
- err  out  1  one-cycle pulse when a load request is rejected

Behaviour:
- Reset, sampled on a clk edge with rst==0:
  - State goes to IDLE; ptr, cnt, idx and the capture registers clear to 0.
  - done and err clear to 0.
  - While rst==0: ram_en, s_ready, res_ready and busy are forced to 0; ram_addr and ram_in are 0.
- Reset during LOAD or COMMIT abandons the operation. No further ram_en pulses occur, no done is issued, and bytes already written remain in the RAM.
- State IDLE:
  - If load_start==1:
    - Reject when load_len==0 or load_base+load_len > MEM_DEPTH (6-bit compare, no wrap). Rejection gives err=1 on the next cycle and the state stays IDLE.
    - Otherwise latch ptr=load_base and cnt=load_len, then go to LOAD.
  - Else if res_valid==1: res_ready=1 (combinational) in the same cycle. The four bytes are captured and idx=0; go to COMMIT.
  - load_start and res_valid in the same cycle: load_start wins and res_ready=0.
- State LOAD:
  - s_ready=1. Writes are combinational pass-through: ram_en = s_valid, ram_addr = ptr, ram_in = s_data.
  - Each accepted byte increments ptr and decrements cnt.
  - Cycles with s_valid==0 produce no write and the state holds.
  - The byte accepted when cnt==1 is the last one; go to DONE. s_ready is 0 from the following cycle.
  - load_start and res_valid are ignored in LOAD.
- State COMMIT:
  - ram_en=1, ram_addr=C_BASE+idx, ram_in=cap[idx], with idx stepping 0..3 on consecutive cycles. Order is c00, c01, c10, c11.
  - After idx==3, go to DONE.
  - Latency: handshake at cycle t gives writes at t+1..t+4 and done at t+5.
  - res_ready=0 in COMMIT.
- State DONE: done=1 for one cycle, no write, then go to IDLE.
- ram_addr never leaves the range 0..MEM_DEPTH-1; the load check guarantees this. No arithmetic is applied to data bytes.
- busy=1 in LOAD, COMMIT and DONE.

Decomposition:
- Shared package holds:
  - The address map constants: A_BASE=0, B_BASE=16, C_BASE=25, MEM_DEPTH=29.
  - ADDR_W and DATA_W.
  - The state encoding IDLE/LOAD/COMMIT/DONE.
- No sub-module: a single FSM with ptr/cnt/idx counters and a 4-byte capture register.

Test Plan:
- Reset: hold rst=0 for 3 cycles with res_valid=1 -> ram_en=0, res_ready=0, s_ready=0, busy=0, done=0, err=0. Release -> res_ready=1 in the same cycle.
- Commit: res_valid with c00..c11=10,20,30,40 accepted at t -> writes (25,10), (26,20), (27,30), (28,40) at t+1..t+4; done at t+5; busy low at t+6.
- Load B: load_base=16, load_len=9, bytes 2,3,2,4,6,5,1,7,1, with s_valid low for 2 cycles after the 3rd byte -> exactly 9 writes to addresses 16..24 with those values, none during the gap; done the cycle after the 9th byte.
- Rejects:
  - load_base=25, load_len=5 -> err pulse, no ram_en, busy stays 0.
  - load_len=0 -> err pulse.
  - load_base=25, load_len=4 -> accepted.
- Conflict: load_start (base 0, len 16) and res_valid in the same cycle -> res_ready=0, LOAD entered; the result is accepted in the cycle after done.
- Mid-op reset: drive rst=0 after 2 commit writes -> no write to 27 or 28, no done pulse, IDLE after release.
